vr_udp_tx_arb: RTL and testbench
================================

# vr_udp_tx_arb

Round-robin arbiter that shares the single UDP transmit path (metadata channel plus data channel) among `NUM_SRC` VR protocol engines, such as the setup, prepare and commit engines. It grants one source per packet and holds the grant from the metadata handshake through the data beat flagged `last`, so packets are never interleaved. It sits between the engines' reply ports and the UDP TX formatter.

## Interface
- `NOC_DATA_W`, default -1 (must be overridden): data beat width in bits.
- `NOC_PADBYTES_W`, default `$clog2(NOC_DATA_W/8)`: padbytes field width.
- `NUM_SRC`, default 3: number of requesters, legal range 2..8.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `src_arb_meta_val` in `NUM_SRC`: per-source metadata valid.
- `src_arb_meta_info` in `udp_info[NUM_SRC]`: per-source UDP metadata.
- `arb_src_meta_rdy` out `NUM_SRC`: per-source metadata ready.
- `src_arb_data_val` in `NUM_SRC`: per-source data valid.
- `src_arb_data` in `[NUM_SRC][NOC_DATA_W]`: per-source data beat.
- `src_arb_data_padbytes` in `[NUM_SRC][NOC_PADBYTES_W]`: per-source padbytes.
- `src_arb_data_last` in `NUM_SRC`: per-source last-beat flag.
- `arb_src_data_rdy` out `NUM_SRC`: per-source data ready.
- `arb_to_udp_meta_val` out 1; `arb_to_udp_meta_info` out `udp_info`; `to_udp_arb_meta_rdy` in 1: downstream metadata channel.
- `arb_to_udp_data_val` out 1; `arb_to_udp_data` out `NOC_DATA_W`; `arb_to_udp_data_padbytes` out `NOC_PADBYTES_W`; `arb_to_udp_data_last` out 1; `to_udp_arb_data_rdy` in 1: downstream data channel.
- `arb_pkt_cnt` out `[NUM_SRC][32]`: present only with `VR_TX_ARB_PKT_CNT_EN`.

## Operation
- **Registers:**
  - `state_reg` holds IDLE, META or DATA.
  - `grant_reg` holds a source index of width `$clog2(NUM_SRC)`.
  - `rr_ptr_reg` holds the highest-priority index.
- **IDLE:**
  - All outputs to the sources and downstream are 0.
  - If any `src_arb_meta_val` bit is set, pick the first set bit scanning from `rr_ptr_reg` upward, wrapping modulo `NUM_SRC`.
  - Load that index into `grant_reg` and go to META.
  - With no request, stay in IDLE.
- **META:**
  - `arb_to_udp_meta_val` = `src_arb_meta_val[grant]`.
  - `arb_to_udp_meta_info` = `src_arb_meta_info[grant]`.
  - `arb_src_meta_rdy[grant]` = `to_udp_arb_meta_rdy`; all other metadata ready bits are 0.
  - On a granted val&rdy, go to DATA.
  - All data ready bits are 0 in META. A source's data is not accepted before its metadata.
- **DATA:**
  - Data, padbytes, last and val are muxed from the granted source.
  - `arb_src_data_rdy[grant]` = `to_udp_arb_data_rdy`; all other data ready bits are 0.
  - On val&rdy&last: go to IDLE and set `rr_ptr_reg` = (grant+1) mod `NUM_SRC`. Wrap-around is explicit because `NUM_SRC` need not be a power of two.
- **Source rules:**
  - Non-granted sources see ready=0 on both channels regardless of their valids.
  - A source must hold val and payload stable until ready (standard val/rdy). The arbiter does not check this.
  - A requester arriving mid-packet waits. It is never granted until the current packet's last beat completes.
- **No timeout:** a granted source that stalls its data holds the path indefinitely.

## Timing
- **Reset values:**
  - `state_reg` = IDLE, `rr_ptr_reg` = 0, `grant_reg` = 0.
  - All `*_val` and `*_rdy` outputs are 0.
  - `arb_pkt_cnt` = 0.
  - Muxed payload outputs are don't-care while their val is 0.
- **Arbitration latency:** a request seen in IDLE in cycle N gives `arb_to_udp_meta_val` = 1 in cycle N+1.
- **Packet gap:** a last-beat handshake in cycle N leaves the arbiter in IDLE in N+1. The next metadata valid appears no earlier than N+2, so there is one bubble per packet.
- **Mux paths:** all muxes and ready steering are combinational from `grant_reg` and `state_reg`. There is no payload register stage.
- **Single-beat packets:** a packet of one beat with `last`=1 uses the DATA state for exactly that beat.
- **Reset mid-packet:**
  - The arbiter returns to IDLE the next edge and drops ready to every source.
  - The partial packet is abandoned; all engines and the UDP formatter share `rst`.
  - `rr_ptr_reg` returns to 0.

## Configuration
- **`VR_TX_ARB_PKT_CNT_EN` defined:**
  - Adds a 32-bit packet counter per source, exposed on `arb_pkt_cnt`.
  - The counter for `grant` increments on each last-beat data handshake and wraps modulo 2^32.
  - The counters are cleared by `rst`.
- **`VR_TX_ARB_PKT_CNT_EN` undefined:** the port and the counters are absent. Arbitration behaviour is identical either way.

## Test plan
- **Single request:** only source 1 requests, with a 1-beat packet, `last`=1 and `padbytes`=63 (512-bit bus). Required: metadata forwarded the cycle after request, data forwarded verbatim, `arb_src_meta_rdy` = 3'b010, return to IDLE.
- **Round-robin rotation:** sources 0, 1 and 2 request continuously, each with 2-beat packets. Required: grant order 0,1,2,0,1,2 with exactly one idle cycle between packets.
- **No interleaving:** source 2 raises `meta_val` during beat 2 of a 4-beat source-0 packet. Required: source 2 is granted only after source 0's last beat, and no source-2 data reaches downstream earlier.
- **Backpressure:** `to_udp_arb_meta_rdy` is held 0 for 5 cycles, then `to_udp_arb_data_rdy` toggles 1,0,1,0. Required: payload stable while stalled, only the granted ready bit asserts, beat count preserved.
- **Reset mid-packet:** assert `rst` during beat 2 of 3. Required: next cycle all val/rdy are 0, `state_reg` = IDLE, and the next grant starts from source 0.
- **Packet counters (`VR_TX_ARB_PKT_CNT_EN` defined):** 3 packets from source 0 and 1 from source 2. Required: `arb_pkt_cnt` = {0: 3, 1: 0, 2: 1}.

Source files
------------

// File: rtl/vr_udp_tx_arb.sv
`default_nettype none
// ============================================================================
// vr_udp_tx_arb : packet-atomic round-robin arbiter sharing the UDP TX path
//                 among NUM_SRC engines. Option macro: VR_TX_ARB_PKT_CNT_EN.
// Revision      : 1.0
// ============================================================================
module vr_udp_tx_arb #(
  parameter int NOC_DATA_W     = -1,
  parameter int NOC_PADBYTES_W = (NOC_DATA_W >= 16) ? $clog2(NOC_DATA_W/8) : 1,
  parameter int NUM_SRC        = 3,
  parameter int UDP_INFO_W     = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC-1:0]                      src_arb_meta_val,
  input  logic [NUM_SRC-1:0][UDP_INFO_W-1:0]      src_arb_meta_info,
  output logic [NUM_SRC-1:0]                      arb_src_meta_rdy,
  input  logic [NUM_SRC-1:0]                      src_arb_data_val,
  input  logic [NUM_SRC-1:0][NOC_DATA_W-1:0]      src_arb_data,
  input  logic [NUM_SRC-1:0][NOC_PADBYTES_W-1:0]  src_arb_data_padbytes,
  input  logic [NUM_SRC-1:0]                      src_arb_data_last,
  output logic [NUM_SRC-1:0]                      arb_src_data_rdy,
  output logic                                    arb_to_udp_meta_val,
  output logic [UDP_INFO_W-1:0]                   arb_to_udp_meta_info,
  input  logic                                    to_udp_arb_meta_rdy,
  output logic                                    arb_to_udp_data_val,
  output logic [NOC_DATA_W-1:0]                   arb_to_udp_data,
  output logic [NOC_PADBYTES_W-1:0]               arb_to_udp_data_padbytes,
  output logic                                    arb_to_udp_data_last,
  input  logic                                    to_udp_arb_data_rdy
`ifdef VR_TX_ARB_PKT_CNT_EN
  ,
  output logic [NUM_SRC-1:0][31:0]                arb_pkt_cnt
`endif
);

  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_META = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t          state_reg, state_nxt;
  logic [GW-1:0]   grant_reg, grant_nxt;
  logic [GW-1:0]   rr_ptr_reg, rr_ptr_nxt;
  logic [GW-1:0]   pick;
  logic            req_any;
  logic            last_hs;
  int              cand;

  // First requester at or after the round-robin pointer, wrapping at NUM_SRC.
  always_comb begin
    pick    = '0;
    req_any = 1'b0;
    cand    = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = (int'(rr_ptr_reg) + i) % NUM_SRC;
      if (!req_any && src_arb_meta_val[cand[GW-1:0]]) begin
        req_any = 1'b1;
        pick    = cand[GW-1:0];
      end
    end
  end

  assign last_hs = (state_reg == ST_DATA) && src_arb_data_val[grant_reg] &&
                   to_udp_arb_data_rdy && src_arb_data_last[grant_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_nxt;
      grant_reg  <= grant_nxt;
      rr_ptr_reg <= rr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt                = state_reg;
    grant_nxt                = grant_reg;
    rr_ptr_nxt               = rr_ptr_reg;
    arb_src_meta_rdy         = '0;
    arb_src_data_rdy         = '0;
    arb_to_udp_meta_val      = 1'b0;
    arb_to_udp_meta_info     = '0;
    arb_to_udp_data_val      = 1'b0;
    arb_to_udp_data          = '0;
    arb_to_udp_data_padbytes = '0;
    arb_to_udp_data_last     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req_any) begin
          grant_nxt = pick;
          state_nxt = ST_META;
        end
      end
      ST_META: begin
        arb_to_udp_meta_val         = src_arb_meta_val[grant_reg];
        arb_to_udp_meta_info        = src_arb_meta_info[grant_reg];
        arb_src_meta_rdy[grant_reg] = to_udp_arb_meta_rdy;
        if (src_arb_meta_val[grant_reg] && to_udp_arb_meta_rdy)
          state_nxt = ST_DATA;
      end
      ST_DATA: begin
        arb_to_udp_data_val         = src_arb_data_val[grant_reg];
        arb_to_udp_data             = src_arb_data[grant_reg];
        arb_to_udp_data_padbytes    = src_arb_data_padbytes[grant_reg];
        arb_to_udp_data_last        = src_arb_data_last[grant_reg];
        arb_src_data_rdy[grant_reg] = to_udp_arb_data_rdy;
        if (last_hs) begin
          state_nxt  = ST_IDLE;
          // NUM_SRC need not be a power of two, so wrap explicitly.
          rr_ptr_nxt = (grant_reg == GW'(NUM_SRC-1)) ? '0 : grant_reg + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

`ifdef VR_TX_ARB_PKT_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      arb_pkt_cnt <= '0;
    else if (last_hs)
      arb_pkt_cnt[grant_reg] <= arb_pkt_cnt[grant_reg] + 32'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_vr_udp_tx_arb.sv
`default_nettype none
// tb_vr_udp_tx_arb: directed and randomized packets from three sources,
// checked cycle by cycle against a packet-ownership reference model.
module tb_vr_udp_tx_arb;
  localparam int DW = 512;
  localparam int PW = 6;
  localparam int N  = 3;
  localparam int IW = 64;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]          s_mval;
  logic [N-1:0][IW-1:0]  s_minfo;
  logic [N-1:0]          a_mrdy;
  logic [N-1:0]          s_dval;
  logic [N-1:0][DW-1:0]  s_data;
  logic [N-1:0][PW-1:0]  s_pad;
  logic [N-1:0]          s_last;
  logic [N-1:0]          a_drdy;
  logic                  u_mval;
  logic [IW-1:0]         u_minfo;
  logic                  u_mrdy;
  logic                  u_dval;
  logic [DW-1:0]         u_data;
  logic [PW-1:0]         u_pad;
  logic                  u_last;
  logic                  u_drdy;
`ifdef VR_TX_ARB_PKT_CNT_EN
  logic [N-1:0][31:0]    pkt_cnt;
`endif

  vr_udp_tx_arb #(
    .NOC_DATA_W(DW), .NOC_PADBYTES_W(PW), .NUM_SRC(N), .UDP_INFO_W(IW)
  ) dut (
    .clk(clk), .rst(rst),
    .src_arb_meta_val(s_mval), .src_arb_meta_info(s_minfo), .arb_src_meta_rdy(a_mrdy),
    .src_arb_data_val(s_dval), .src_arb_data(s_data), .src_arb_data_padbytes(s_pad),
    .src_arb_data_last(s_last), .arb_src_data_rdy(a_drdy),
    .arb_to_udp_meta_val(u_mval), .arb_to_udp_meta_info(u_minfo), .to_udp_arb_meta_rdy(u_mrdy),
    .arb_to_udp_data_val(u_dval), .arb_to_udp_data(u_data),
    .arb_to_udp_data_padbytes(u_pad), .arb_to_udp_data_last(u_last),
    .to_udp_arb_data_rdy(u_drdy)
`ifdef VR_TX_ARB_PKT_CNT_EN
    , .arb_pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which source owns the path, and whether its metadata went.
  int          m_owner = -1;
  bit          m_meta_done = 1'b0;
  int          m_rr = 0;
  logic [31:0] m_cnt [N];

  // Source drivers and knobs (percent probabilities).
  int pend [N];
  int plen [N];
  int beats_left [N];
  bit in_data [N];
  int p_val = 100, p_mrdy = 100, p_drdy = 100, pad_fix = -1;
  logic [N-1:0] hs_m, hs_d;
  logic hs_last;
  int exp_beats = 0, dut_beats = 0;
  int grant_q [$];

  task automatic check_value(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit pct(input int p);
    return (int'($urandom_range(99, 0)) < p);
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] e_mrdy, e_drdy;
    logic e_mval, e_dval;
    logic [1:0] o;
    e_mrdy = '0; e_drdy = '0; e_mval = 1'b0; e_dval = 1'b0;
    o = 2'((m_owner < 0) ? 0 : m_owner);
    if (m_owner >= 0 && !m_meta_done) begin e_mval = s_mval[o]; e_mrdy[o] = u_mrdy; end
    if (m_owner >= 0 && m_meta_done)  begin e_dval = s_dval[o]; e_drdy[o] = u_drdy; end
    check_value("meta_val", DW'(u_mval), DW'(e_mval));
    check_value("meta_rdy", DW'(a_mrdy), DW'(e_mrdy));
    check_value("data_val", DW'(u_dval), DW'(e_dval));
    check_value("data_rdy", DW'(a_drdy), DW'(e_drdy));
    if (e_mval) check_value("meta_info", DW'(u_minfo), DW'(s_minfo[o]));
    if (e_dval) begin
      check_value("data", u_data, s_data[o]);
      check_value("data_pad", DW'(u_pad), DW'(s_pad[o]));
      check_value("data_last", DW'(u_last), DW'(s_last[o]));
    end
`ifdef VR_TX_ARB_PKT_CNT_EN
    for (int s = 0; s < N; s++)
      check_value($sformatf("pkt_cnt%0d", s), DW'(pkt_cnt[s]), DW'(m_cnt[s]));
`endif
    hs_m    = e_mrdy & {N{e_mval}};
    hs_d    = e_drdy & {N{e_dval}};
    hs_last = s_last[o];
    if (|hs_d) exp_beats++;
    if (u_dval && u_drdy) dut_beats++;
    if (u_mval && u_mrdy)
      for (int s = 0; s < N; s++) if (a_mrdy[s]) grant_q.push_back(s);
  endtask

  task automatic model_update();
    if (rst) begin
      m_owner = -1; m_meta_done = 1'b0; m_rr = 0;
      for (int s = 0; s < N; s++) m_cnt[s] = '0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (m_owner < 0 && s_mval[2'(c)]) m_owner = c;
      end
    end else if (!m_meta_done) begin
      if (|hs_m) m_meta_done = 1'b1;
    end else if ((|hs_d) && hs_last) begin
      m_cnt[m_owner] = m_cnt[m_owner] + 32'd1;
      m_rr = (m_owner + 1) % N;
      m_owner = -1;
      m_meta_done = 1'b0;
    end
  endtask

  task automatic driver_update(input bit was_rst);
    for (int s = 0; s < N; s++) begin
      if (was_rst) begin
        s_mval[s] = 1'b0; s_dval[s] = 1'b0; in_data[s] = 1'b0; beats_left[s] = 0;
      end else begin
        if (hs_m[s]) begin s_mval[s] = 1'b0; in_data[s] = 1'b1; end
        if (hs_d[s]) begin
          s_dval[s] = 1'b0;
          beats_left[s]--;
          if (beats_left[s] == 0) begin in_data[s] = 1'b0; pend[s]--; end
        end
        if (!in_data[s] && pend[s] > 0 && !s_mval[s] && pct(p_val)) begin
          s_mval[s]     = 1'b1;
          s_minfo[s]    = {$urandom, $urandom};
          beats_left[s] = (plen[s] > 0) ? plen[s] : int'($urandom_range(4, 1));
        end
        if (in_data[s] && !s_dval[s] && pct(p_val)) begin
          s_dval[s] = 1'b1;
          s_data[s] = rand_data();
          s_last[s] = (beats_left[s] == 1);
          s_pad[s]  = (s_last[s] && pad_fix >= 0) ? PW'(pad_fix) : PW'($urandom);
        end
      end
    end
    u_mrdy = pct(p_mrdy);
    u_drdy = pct(p_drdy);
  endtask

  task automatic cycle();
    bit was_rst;
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    was_rst = rst;
    model_update();
    #1;
    driver_update(was_rst);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    grant_q.delete();
    exp_beats = 0;
    dut_beats = 0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      cycle();
      n++;
      busy = (m_owner >= 0);
      for (int s = 0; s < N; s++) if (pend[s] > 0) busy = 1'b1;
    end
    check_value(tag, DW'(busy), '0);
  endtask

  task automatic check_order(input string tag, input int exp_q [$]);
    check_value({tag, "_len"}, DW'(grant_q.size()), DW'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < grant_q.size(); i++)
      check_value($sformatf("%s%0d", tag, i), DW'(grant_q[i]), DW'(exp_q[i]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    s_mval = '0; s_minfo = '0; s_dval = '0; s_data = '0; s_pad = '0; s_last = '0;
    u_mrdy = 1'b0; u_drdy = 1'b0; hs_m = '0; hs_d = '0; hs_last = 1'b0;
    for (int s = 0; s < N; s++) begin
      pend[s] = 0; plen[s] = 0; beats_left[s] = 0; in_data[s] = 1'b0; m_cnt[s] = '0;
    end
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 1'b0;
    u_mrdy = 1'b1; u_drdy = 1'b1;

    // Single one-beat request from source 1 with maximal padbytes.
    pend[1] = 1; plen[1] = 1; pad_fix = 63;
    drain("s1_drain", 50);
    check_order("s1_order", '{1});
    check_value("s1_beats", DW'(dut_beats), DW'(1));
    pad_fix = -1;

    // Continuous two-beat requests from all sources rotate 0,1,2,0,1,2.
    pulse_reset();
    for (int s = 0; s < N; s++) begin pend[s] = 2; plen[s] = 2; end
    drain("s2_drain", 200);
    check_order("s2_order", '{0, 1, 2, 0, 1, 2});

    // Source 2 arrives during beat 2 of a 4-beat source-0 packet.
    pulse_reset();
    pend[0] = 1; plen[0] = 4; plen[2] = 2;
    n = 0;
    while (!(in_data[0] && beats_left[0] == 3) && n < 50) begin cycle(); n++; end
    check_value("s3_reach", DW'(n < 50), DW'(1));
    pend[2] = 1;
    drain("s3_drain", 100);
    check_order("s3_order", '{0, 2});

    // Metadata stall then data backpressure.
    pulse_reset();
    p_mrdy = 0; pend[1] = 1; plen[1] = 4;
    repeat (6) cycle();
    p_mrdy = 100; p_drdy = 50;
    drain("s4_drain", 200);
    check_value("s4_beats", DW'(dut_beats), DW'(4));
    check_order("s4_order", '{1});
    p_drdy = 100;

    // Reset during beat 2 of 3; pointer must restart at source 0.
    pulse_reset();
    pend[1] = 1; plen[1] = 1;
    drain("s5_pre", 50);
    pend[0] = 1; plen[0] = 3;
    n = 0;
    while (!(in_data[0] && beats_left[0] == 2) && n < 50) begin cycle(); n++; end
    check_value("s5_reach", DW'(n < 50), DW'(1));
    pulse_reset();
    for (int s = 0; s < N; s++) plen[s] = 1;
    pend[1] = 1; pend[2] = 1;
    drain("s5_drain", 100);
    check_order("s5_order", '{0, 1, 2});

`ifdef VR_TX_ARB_PKT_CNT_EN
    pulse_reset();
    for (int s = 0; s < N; s++) plen[s] = 0;
    pend[0] = 3; pend[2] = 1;
    drain("s6_drain", 300);
    check_value("cnt0", DW'(pkt_cnt[0]), DW'(3));
    check_value("cnt1", DW'(pkt_cnt[1]), DW'(0));
    check_value("cnt2", DW'(pkt_cnt[2]), DW'(1));
`endif

    // Randomized traffic with occasional resets.
    pulse_reset();
    for (int it = 0; it < 40; it++) begin
      p_val  = int'($urandom_range(100, 30));
      p_mrdy = int'($urandom_range(100, 20));
      p_drdy = int'($urandom_range(100, 20));
      for (int s = 0; s < N; s++) begin
        plen[s] = 0;
        if (pend[s] == 0) pend[s] = int'($urandom_range(3, 0));
      end
      repeat ($urandom_range(60, 10)) cycle();
      if ($urandom_range(9, 0) == 0) begin
        rst = 1'b1; cycle(); rst = 1'b0;
      end
    end
    drain("rand_drain", 3000);
    check_value("rand_beats", DW'(dut_beats), DW'(exp_beats));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
